// File: rtl/fetch_pc_control_if.sv
// Fetch-PC control bus: redirect inputs from the EX/hazard side and the fetch
// address, flush and status outputs of the PC control block.
interface fetch_pc_control_if;
   logic        stall;
   logic        ex_valid;
   logic        branch_taken;
   logic        JAL;
   logic        JALR;
   logic [31:0] ex_pc;
   logic [31:0] Immb_BSE;
   logic [31:0] Immb_JSE;
   logic [31:0] Imm_I;
   logic [31:0] rs1_val;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        flush;
   logic        misalign;
   logic [15:0] redirect_count;

   modport master (
      output stall, ex_valid, branch_taken, JAL, JALR,
      output ex_pc, Immb_BSE, Immb_JSE, Imm_I, rs1_val,
      input  pc, pc_plus4, flush, misalign, redirect_count
   );

   modport slave (
      input  stall, ex_valid, branch_taken, JAL, JALR,
      input  ex_pc, Immb_BSE, Immb_JSE, Imm_I, rs1_val,
      output pc, pc_plus4, flush, misalign, redirect_count
   );
endinterface

// File: rtl/fetch_pc_control.sv
// Fetch PC sequencer: sequential fetch, EX-stage redirects (JALR > JAL > branch),
// a two-cycle wrong-path flush window, misaligned-target trap and redirect count.
module fetch_pc_control #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
   input logic               clk,
   input logic               rst_n,
   fetch_pc_control_if.slave bus
);
   typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

   state_t      state;
   logic [1:0]  flush_cnt;
   logic [31:0] pc_q;
   logic        misalign_q;
   logic [15:0] redirect_count_q;

   logic        redirect_req;
   logic        accept;
   logic        tgt_misaligned;
   logic [31:0] target;
   logic [31:0] pc_plus4;

   assign redirect_req = bus.ex_valid & (bus.JALR | bus.JAL | bus.branch_taken);
   // Redirects arriving during the flush window belong to squashed instructions.
   assign accept       = redirect_req & (state == ST_RUN);
   assign pc_plus4     = pc_q + 32'd4;

   always_comb begin
      // NOTE: target gets a default first, so no path through this block can infer a latch.
      target = bus.ex_pc + bus.Immb_BSE;
      if (bus.JALR)
         target = (bus.rs1_val + bus.Imm_I) & 32'hFFFF_FFFE;
      else if (bus.JAL)
         target = bus.ex_pc + bus.Immb_JSE;
   end

   assign tgt_misaligned = |target[1:0];

   // NOTE: all state is updated with non-blocking assignments so every read sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= ST_RUN;
         flush_cnt        <= 2'd0;
         pc_q             <= RESET_PC;
         misalign_q       <= 1'b0;
         redirect_count_q <= 16'd0;
      end else begin
         misalign_q <= 1'b0;
         if (accept) begin
            pc_q       <= tgt_misaligned ? TRAP_VEC : target;
            misalign_q <= tgt_misaligned;
            state      <= ST_FLUSH;
            flush_cnt  <= 2'd2;
            if (redirect_count_q != 16'hFFFF)
               redirect_count_q <= redirect_count_q + 16'd1;
         end else begin
            if (!bus.stall)
               pc_q <= pc_plus4;
            if (state == ST_FLUSH) begin
               flush_cnt <= flush_cnt - 2'd1;
               if (flush_cnt == 2'd1)
                  state <= ST_RUN;
            end
         end
      end
   end

   assign bus.pc             = pc_q;
   assign bus.pc_plus4       = pc_plus4;
   assign bus.flush          = (state == ST_FLUSH);
   assign bus.misalign       = misalign_q;
   assign bus.redirect_count = redirect_count_q;
endmodule

// File: tb/tb_fetch_pc_control.sv
// Self-checking bench for fetch_pc_control: directed scenarios plus random
// redirect/stall traffic compared against a behavioural fetch model.
module tb_fetch_pc_control;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   // Behavioural model: fetch address, remaining flush cycles, pulse, count.
   logic [31:0] m_pc;
   int          m_flush_left;
   logic        m_mis;
   int          m_count;

   fetch_pc_control_if bif ();

   fetch_pc_control #(.RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".pc"}, bif.pc, m_pc);
      check({tag, ".pc_plus4"}, bif.pc_plus4, m_pc + 32'd4);
      check({tag, ".flush"}, {31'd0, bif.flush}, {31'd0, m_flush_left > 0});
      check({tag, ".misalign"}, {31'd0, bif.misalign}, {31'd0, m_mis});
      check({tag, ".count"}, {16'd0, bif.redirect_count}, m_count[31:0]);
   endtask

   task automatic clr_redirect();
      bif.ex_valid     = 1'b0;
      bif.branch_taken = 1'b0;
      bif.JAL          = 1'b0;
      bif.JALR         = 1'b0;
   endtask

   task automatic model_reset();
      m_pc         = RESET_PC;
      m_flush_left = 0;
      m_mis        = 1'b0;
      m_count      = 0;
   endtask

   // Apply the currently driven inputs for one clock edge, then compare at the negedge.
   task automatic cycle(input string tag);
      logic [31:0] tgt;
      bit          req;
      req = bif.ex_valid && (bif.JALR || bif.JAL || bif.branch_taken);
      if (m_flush_left == 0 && req) begin
         if (bif.JALR)     tgt = ((bif.rs1_val + bif.Imm_I) / 2) * 2;
         else if (bif.JAL) tgt = bif.ex_pc + bif.Immb_JSE;
         else              tgt = bif.ex_pc + bif.Immb_BSE;
         m_mis        = (tgt % 4) != 0;
         m_pc         = m_mis ? TRAP_VEC : tgt;
         m_flush_left = 2;
         m_count      = (m_count >= 65535) ? 65535 : m_count + 1;
      end else begin
         m_mis = 1'b0;
         if (!bif.stall) m_pc = m_pc + 32'd4;
         if (m_flush_left > 0) m_flush_left--;
      end
      @(negedge clk);
      check_all(tag);
   endtask

   initial begin
      rst_n            = 1'b0;
      bif.stall        = 1'b0;
      bif.ex_pc        = '0;
      bif.Immb_BSE     = '0;
      bif.Immb_JSE     = '0;
      bif.Imm_I        = '0;
      bif.rs1_val      = '0;
      clr_redirect();
      model_reset();

      // Reset values hold before any clock edge.
      #2;
      check_all("reset");
      @(negedge clk);
      rst_n = 1'b1;
      check_all("release");

      // Sequential fetch.
      for (int i = 0; i < 3; i++) cycle("seq");
      check("seq_pc_c", bif.pc, 32'h0000_000C);

      // Walk to 0x40, then backwards branch to 0x28.
      for (int i = 0; i < 40 && m_pc != 32'h40; i++) cycle("walk");
      bif.ex_valid = 1'b1; bif.branch_taken = 1'b1;
      bif.ex_pc = 32'h38; bif.Immb_BSE = 32'hFFFF_FFF0;
      cycle("branch");
      check("branch_pc", bif.pc, 32'h0000_0028);
      check("branch_cnt", {16'd0, bif.redirect_count}, 32'd1);
      clr_redirect();
      cycle("branch_fl1");
      cycle("branch_fl2");
      cycle("branch_run");
      check("branch_flush_end", {31'd0, bif.flush}, 32'd0);

      // JAL and JALR together: JALR wins, bit 0 cleared.
      bif.ex_valid = 1'b1; bif.JAL = 1'b1; bif.JALR = 1'b1;
      bif.rs1_val = 32'h1001; bif.Imm_I = 32'h10; bif.Immb_JSE = 32'h200;
      cycle("jalr_prio");
      check("jalr_prio_pc", bif.pc, 32'h0000_1010);
      clr_redirect();
      cycle("jalr_fl1");
      cycle("jalr_fl2");

      // Misaligned JALR target traps.
      bif.ex_valid = 1'b1; bif.JALR = 1'b1;
      bif.rs1_val = 32'h1000; bif.Imm_I = 32'h2;
      cycle("mis");
      check("mis_pc", bif.pc, TRAP_VEC);
      check("mis_pulse", {31'd0, bif.misalign}, 32'd1);
      clr_redirect();
      cycle("mis_fl1");
      check("mis_pulse_end", {31'd0, bif.misalign}, 32'd0);
      cycle("mis_fl2");
      cycle("mis_run");

      // Redirect beats stall; redirect during the flush window is ignored.
      bif.stall = 1'b1;
      bif.ex_valid = 1'b1; bif.branch_taken = 1'b1;
      bif.ex_pc = 32'h200; bif.Immb_BSE = 32'h40;
      cycle("stall_br");
      check("stall_br_pc", bif.pc, 32'h0000_0240);
      bif.branch_taken = 1'b0; bif.JAL = 1'b1;
      bif.ex_pc = 32'h0; bif.Immb_JSE = 32'h800;
      cycle("flush_ignore");
      check("flush_ignore_pc", bif.pc, 32'h0000_0240);
      check("flush_ignore_cnt", {16'd0, bif.redirect_count}, 32'd4);
      clr_redirect();
      bif.stall = 1'b0;
      cycle("ign_fl2");

      // ex_valid=0 redirect has no effect.
      bif.JAL = 1'b1; bif.ex_pc = 32'h0; bif.Immb_JSE = 32'h3000;
      cycle("not_valid");
      clr_redirect();

      // Reset mid-flush abandons the flush.
      bif.ex_valid = 1'b1; bif.JAL = 1'b1; bif.Immb_JSE = 32'h500;
      cycle("pre_rst");
      clr_redirect();
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all("mid_flush_rst");
      @(negedge clk);
      rst_n = 1'b1;
      cycle("post_rst");
      check("post_rst_pc", bif.pc, RESET_PC + 32'd4);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         bif.stall        = ($urandom_range(0, 3) == 0);
         bif.ex_valid     = ($urandom_range(0, 2) != 0);
         bif.branch_taken = $urandom_range(0, 1);
         bif.JAL          = ($urandom_range(0, 3) == 0);
         bif.JALR         = ($urandom_range(0, 3) == 0);
         bif.ex_pc        = $urandom & 32'hFFFF_FFFC;
         bif.Immb_BSE     = ($urandom_range(0, 5) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
         bif.Immb_JSE     = ($urandom_range(0, 5) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
         bif.Imm_I        = $urandom;
         bif.rs1_val      = ($urandom_range(0, 1) == 0) ? ($urandom & 32'hFFFF_FFFC) : $urandom;
         cycle("rand");
      end
      clr_redirect();
      bif.stall = 1'b0;
      cycle("drain1");
      cycle("drain2");

      // Counter saturation and pc wrap.
      force dut.redirect_count_q = 16'hFFFF;
      #1;
      release dut.redirect_count_q;
      m_count = 65535;
      check("preload_cnt", {16'd0, bif.redirect_count}, 32'h0000_FFFF);
      bif.ex_valid = 1'b1; bif.JAL = 1'b1;
      bif.ex_pc = 32'h0; bif.Immb_JSE = 32'hFFFF_FFFC;
      cycle("sat");
      check("sat_cnt", {16'd0, bif.redirect_count}, 32'h0000_FFFF);
      check("wrap_pc", bif.pc, 32'hFFFF_FFFC);
      clr_redirect();
      bif.stall = 1'b1;
      cycle("wrap_fl1");
      cycle("wrap_fl2");
      check("wrap_plus4", bif.pc_plus4, 32'h0000_0000);
      bif.stall = 1'b0;
      cycle("wrap");
      check("wrap_zero", bif.pc, 32'h0000_0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fetch_pc_control.md
FETCH_PC_CONTROL -- requirements
Module: fetch_pc_control

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, fetch address loaded on reset.
REQ-002 Parameter TRAP_VEC, default 32'h0000_0100, fetch address loaded on a misaligned redirect target.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 stall  input  1  hazard-unit fetch hold.
REQ-007 ex_valid  input  1  instruction in EX is live, not squashed.
REQ-008 branch_taken  input  1  EX branch condition true.
REQ-009 JAL  input  1  EX instruction is JAL.
REQ-010 JALR  input  1  EX instruction is JALR.
REQ-011 ex_pc  input  32  PC of the EX instruction.
REQ-012 Immb_BSE  input  32  sign-extended B-type offset.
REQ-013 Immb_JSE  input  32  sign-extended J-type offset.
REQ-014 Imm_I  input  32  sign-extended I-type offset.
REQ-015 rs1_val  input  32  forwarded rs1 operand.
REQ-016 pc  output  32  current fetch address, registered.
REQ-017 pc_plus4  output  32  pc + 4, combinational.
REQ-018 flush  output  1  squash wrong-path IF/ID and ID/EX, registered.
REQ-019 misalign  output  1  one-cycle misaligned-target pulse, registered.
REQ-020 redirect_count  output  16  saturating count of accepted redirects.

Function
REQ-021 redirect_req SHALL equal ex_valid & (JALR | JAL | branch_taken); it is accepted only in state RUN.
REQ-022 Target selection priority SHALL be JALR > JAL > branch.
REQ-023 JALR target SHALL be (rs1_val + Imm_I) with bit 0 forced to 0.
REQ-024 JAL target SHALL be ex_pc + Immb_JSE.
REQ-025 Branch target SHALL be ex_pc + Immb_BSE.
REQ-026 All adds SHALL be 32-bit modulo 2^32 with no carry-out; pc_plus4 likewise wraps (32'hFFFF_FFFC -> 0).
REQ-027 FSM states SHALL be RUN and FLUSH, with a 2-bit flush counter.
REQ-028 In RUN with no accepted redirect: pc holds if stall=1, else pc <= pc_plus4.
REQ-029 Accepted redirect (RUN): at that edge pc <= target, state <= FLUSH, counter <= 2; stall is ignored (redirect beats stall).
REQ-030 If target[1:0] != 2'b00 on an accepted redirect, pc SHALL instead load TRAP_VEC, misalign SHALL be 1 for exactly the next cycle, and the FLUSH entry is unchanged.
REQ-031 flush SHALL be 1 exactly while state = FLUSH, i.e. the 2 cycles following the redirect edge; it is 0 in RUN.
REQ-032 In FLUSH: counter decrements each edge regardless of stall; at counter 1 -> 0, state returns to RUN.
REQ-033 In FLUSH: pc holds if stall=1, else pc <= pc_plus4.
REQ-034 In FLUSH: redirect_req SHALL be ignored, with no pc change and no count.
REQ-035 redirect_count SHALL increment by 1 on each accepted redirect, including misaligned ones, and saturate at 16'hFFFF.
REQ-036 Redirect with ex_valid=0 SHALL have no effect.

Reset
REQ-037 While rst_n=0, independent of clk: pc=RESET_PC, state=RUN, counter=0, flush=0, misalign=0, redirect_count=0.
REQ-038 Reset asserted mid-FLUSH SHALL abandon the flush immediately; the first edge after release fetches RESET_PC+4 (if stall=0).

Verification
REQ-039 Reset release, stall=0, no redirect, 3 edges -> pc 0x0, 0x4, 0x8, 0xC; flush=0 throughout.
REQ-040 pc=0x40, ex_pc=0x38, branch_taken=1, ex_valid=1, Immb_BSE=0xFFFF_FFF0 -> next pc=0x28; flush=1 for 2 cycles; redirect_count=1.
REQ-041 JAL=1 and JALR=1 together, rs1_val=0x1001, Imm_I=0x10, Immb_JSE=0x200 -> pc=0x1010 (JALR wins, bit 0 cleared).
REQ-042 JALR target 0x1002 -> pc=TRAP_VEC 0x100, misalign=1 for one cycle, flush=1 for 2 cycles.
REQ-043 stall=1 with simultaneous accepted branch -> pc takes target; a second redirect in the following FLUSH cycle -> ignored, count unchanged.
REQ-044 Preload redirect_count=0xFFFF (1 more redirect) -> stays 0xFFFF; pc=0xFFFF_FFFC, stall=0 -> pc=0x0.
